// File: rtl/alu_share_ctrl_pkg.sv
// rtl/alu_share_ctrl_pkg.sv - shared ALU controller types: op codes, command, flags, FSM states
package alu_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_SHL  = 3'd5,
    OP_SHR  = 3'd6,
    OP_PASS = 3'd7
  } alu_op_e;

  typedef struct packed {
    alu_op_e    op;
    logic [3:0] shift;
    logic [7:0] a;
    logic [7:0] b;
  } alu_cmd_t;

  typedef struct packed {
    logic overflow;
    logic carry;
    logic cero;
  } alu_flags_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } ctrl_state_e;

  localparam int CMD_W = $bits(alu_cmd_t);

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// rtl/alu_share_ctrl_rr_arb2.sv - two-way round-robin grant; a tie goes to the requester not granted last
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// rtl/alu_share_ctrl.sv - shares one external ALU between two requesters, one operation in flight
// Optional sticky flag accumulator enabled by ALU_SHARE_STICKY_EN.
module alu_share_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ALU_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef ALU_SHARE_STICKY_EN
  input  logic               sticky_clr,
  output logic [2:0]         sticky_flags,
`endif
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*CMD_W-1:0] req_cmd,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [DATA_W-1:0]  rsp_y,
  output logic [2:0]         rsp_flags,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [2:0]         alu_s,
  output logic [3:0]         alu_shift,
  input  logic [DATA_W-1:0]  alu_y,
  input  logic               alu_cero,
  input  logic               alu_carry,
  input  logic               alu_overflow
);

  localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

  ctrl_state_e       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [DATA_W-1:0] rsp_y_q, rsp_y_d;
  logic [2:0]        alu_s_q, alu_s_d;
  logic [3:0]        alu_shift_q, alu_shift_d;
  logic              rsp_id_q, rsp_id_d;
  logic              last_grant_q, last_grant_d;
  alu_flags_t        rsp_flags_q, rsp_flags_d;
  alu_flags_t        alu_flags;
  alu_cmd_t          cmd_sel;
  logic [1:0]        grant, accept;
  logic              arb_en, capture;

  // Gating by rst_n keeps req_ready at 0 while reset is held.
  assign arb_en = rst_n && (state_q == IDLE);

  rr_arb2 u_arb (
    .valid      (req_valid),
    .last_grant (last_grant_q),
    .enable     (arb_en),
    .grant      (grant)
  );

  assign accept    = req_valid & grant;
  assign cmd_sel   = accept[1] ? alu_cmd_t'(req_cmd[2*CMD_W-1:CMD_W]) : alu_cmd_t'(req_cmd[CMD_W-1:0]);
  assign alu_flags = '{overflow: alu_overflow, carry: alu_carry, cero: alu_cero};
  assign capture   = (state_q == EXEC) && (cnt_q == 4'd0);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_s_d      = alu_s_q;
    alu_shift_d  = alu_shift_q;
    rsp_id_d     = rsp_id_q;
    last_grant_d = last_grant_q;
    rsp_y_d      = rsp_y_q;
    rsp_flags_d  = rsp_flags_q;
    case (state_q)
      IDLE: begin
        if (accept != 2'b00) begin
          alu_a_d      = DATA_W'(cmd_sel.a);
          alu_b_d      = DATA_W'(cmd_sel.b);
          alu_s_d      = cmd_sel.op;
          alu_shift_d  = cmd_sel.shift;
          rsp_id_d     = accept[1];
          last_grant_d = accept[1];
          cnt_d        = CNT_INIT;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        if (capture) begin
          rsp_y_d     = alu_y;
          rsp_flags_d = alu_flags;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_s_q      <= '0;
      alu_shift_q  <= '0;
      rsp_id_q     <= 1'b0;
      last_grant_q <= 1'b1;
      rsp_y_q      <= '0;
      rsp_flags_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_s_q      <= alu_s_d;
      alu_shift_q  <= alu_shift_d;
      rsp_id_q     <= rsp_id_d;
      last_grant_q <= last_grant_d;
      rsp_y_q      <= rsp_y_d;
      rsp_flags_q  <= rsp_flags_d;
    end
  end

`ifdef ALU_SHARE_STICKY_EN
  logic [2:0] sticky_q, sticky_d;

  // Clear first, then OR in: a same-cycle clear and capture leaves just the new flags.
  always_comb begin
    sticky_d = sticky_clr ? 3'b000 : sticky_q;
    if (capture) sticky_d = sticky_d | alu_flags;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) sticky_q <= 3'b000;
    else        sticky_q <= sticky_d;
  end

  assign sticky_flags = sticky_q;
`endif

  assign req_ready = grant;
  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_flags = rsp_flags_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_s     = alu_s_q;
  assign alu_shift = alu_shift_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb/tb_alu_share_ctrl.sv - directed bench for alu_share_ctrl (ALU_LAT=1 and ALU_LAT=3 instances)
module tb_alu_share_ctrl;
  import alu_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  req_valid, req_ready;
  logic [45:0] req_cmd;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [7:0]  rsp_y, alu_a, alu_b, alu_y;
  logic [2:0]  rsp_flags, alu_s;
  logic [3:0]  alu_shift;
  logic        alu_cero, alu_carry, alu_overflow;

  logic [1:0]  req_valid3, req_ready3;
  logic [45:0] req_cmd3;
  logic        rsp_valid3, rsp_ready3, rsp_id3;
  logic [7:0]  rsp_y3, alu_a3, alu_b3, alu_y3;
  logic [2:0]  rsp_flags3, alu_s3;
  logic [3:0]  alu_shift3;
  logic        alu_cero3, alu_carry3, alu_overflow3;

`ifdef ALU_SHARE_STICKY_EN
  logic       sticky_clr, sticky_clr3;
  logic [2:0] sticky_flags, sticky_flags3;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int g[$];
  int r[$];
  int ys[$];
  logic [7:0] oy;
  logic [2:0] ofl;
  logic       oid;

  // Reference ALU standing in for the shared datapath: {overflow, carry, cero, y}.
  function automatic logic [10:0] alu_model(input logic [2:0] s, input logic [3:0] sh,
                                            input logic [7:0] a, input logic [7:0] b);
    logic [7:0] y;
    logic       c, v;
    c = 1'b0;
    v = 1'b0;
    case (s)
      3'd0: begin {c, y} = {1'b0, a} + {1'b0, b}; v = (a[7] == b[7]) && (y[7] != a[7]); end
      3'd1: begin {c, y} = {1'b0, a} - {1'b0, b}; v = (a[7] != b[7]) && (y[7] != a[7]); end
      3'd2: y = a & b;
      3'd3: y = a | b;
      3'd4: y = a ^ b;
      3'd5: y = a << sh;
      3'd6: y = a >> sh;
      default: y = b;
    endcase
    return {v, c, (y == 8'h00), y};
  endfunction

  function automatic logic [22:0] mk(input logic [2:0] op, input logic [3:0] sh,
                                     input logic [7:0] a, input logic [7:0] b);
    return {op, sh, a, b};
  endfunction

  assign {alu_overflow, alu_carry, alu_cero, alu_y}     = alu_model(alu_s, alu_shift, alu_a, alu_b);
  assign {alu_overflow3, alu_carry3, alu_cero3, alu_y3} = alu_model(alu_s3, alu_shift3, alu_a3, alu_b3);

  alu_share_ctrl #(.DATA_W(8), .ALU_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef ALU_SHARE_STICKY_EN
    .sticky_clr(sticky_clr), .sticky_flags(sticky_flags),
`endif
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_flags(rsp_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_shift(alu_shift),
    .alu_y(alu_y), .alu_cero(alu_cero), .alu_carry(alu_carry), .alu_overflow(alu_overflow)
  );

  alu_share_ctrl #(.DATA_W(8), .ALU_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
`ifdef ALU_SHARE_STICKY_EN
    .sticky_clr(sticky_clr3), .sticky_flags(sticky_flags3),
`endif
    .req_valid(req_valid3), .req_ready(req_ready3), .req_cmd(req_cmd3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_id(rsp_id3), .rsp_y(rsp_y3), .rsp_flags(rsp_flags3),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_s(alu_s3), .alu_shift(alu_shift3),
    .alu_y(alu_y3), .alu_cero(alu_cero3), .alu_carry(alu_carry3), .alu_overflow(alu_overflow3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
  endtask

  // One complete transaction on the ALU_LAT=1 instance with rsp_ready held high.
  task automatic do_op(input int who, input logic [22:0] cmd,
                       output logic [7:0] y, output logic [2:0] fl, output logic id);
    int t;
    y  = '0;
    fl = '0;
    id = 1'b0;
    req_cmd[who*23 +: 23] = cmd;
    req_valid[who] = 1'b1;
    t = 0;
    while (!req_ready[who] && t < 20) begin @(posedge clk); #1; t++; end
    if (t >= 20) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    t = 0;
    while (!rsp_valid && t < 20) begin @(posedge clk); #1; t++; end
    if (t >= 20) chk("rsp_timeout", 0, 1);
    y  = rsp_y;
    fl = rsp_flags;
    id = rsp_id;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req_valid = 2'b00; req_cmd = '0; rsp_ready = 1'b1;
    req_valid3 = 2'b00; req_cmd3 = '0; rsp_ready3 = 1'b1;
`ifdef ALU_SHARE_STICKY_EN
    sticky_clr = 1'b0; sticky_clr3 = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_alu_a",     32'(alu_a), 0);
    chk("rst_rsp_y",     32'(rsp_y), 0);
    chk("rst_rsp_flags", 32'(rsp_flags), 0);

    // 1: single ADD, latency and cmd sampled only at accept
    rst_n = 1'b1;
    req_cmd[22:0] = mk(OP_ADD, 4'd0, 8'h05, 8'h03);
    req_valid = 2'b01;
    chk("t1_ready", 32'(req_ready), 1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    req_cmd[22:0] = mk(OP_XOR, 4'd0, 8'hAA, 8'h55);
    chk("t1_exec_alu_a", 32'(alu_a), 32'h05);
    chk("t1_exec_alu_b", 32'(alu_b), 32'h03);
    chk("t1_exec_valid", 32'(rsp_valid), 0);
    chk("t1_exec_ready", 32'(req_ready), 0);
    @(posedge clk); #1;
    chk("t1_rsp_valid", 32'(rsp_valid), 1);
    chk("t1_rsp_id",    32'(rsp_id), 0);
    chk("t1_rsp_y",     32'(rsp_y), 32'h08);
    chk("t1_rsp_flags", 32'(rsp_flags), 0);
    @(posedge clk); #1;
    chk("t1_done_valid", 32'(rsp_valid), 0);
    chk("t1_alu_a_kept", 32'(alu_a), 32'h05);

    // 2: both requesters valid every cycle -> alternating grants
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    req_cmd = {mk(OP_ADD, 4'd0, 8'h10, 8'h10), mk(OP_ADD, 4'd0, 8'h01, 8'h01)};
    req_valid = 2'b11;
    for (int i = 0; i < 12; i++) begin
      if (req_ready != 2'b00) g.push_back(req_ready[1] ? 1 : 0);
      if (rsp_valid) begin r.push_back(rsp_id ? 1 : 0); ys.push_back(int'(rsp_y)); end
      if (i == 11) req_valid = 2'b00;
      @(posedge clk); #1;
    end
    chk("t2_n_grants", 32'(g.size()), 4);
    chk("t2_n_rsps",   32'(r.size()), 4);
    for (int k = 0; k < 4 && k < g.size() && k < r.size(); k++) begin
      chk("t2_grant_order", 32'(g[k]), 32'(k % 2));
      chk("t2_rsp_id_order", 32'(r[k]), 32'(k % 2));
      chk("t2_rsp_y", 32'(ys[k]), (k % 2 == 1) ? 32'h20 : 32'h02);
    end

    // 3: carry/zero and signed overflow
    do_op(0, mk(OP_ADD, 4'd0, 8'hFF, 8'h01), oy, ofl, oid);
    chk("t3a_y", 32'(oy), 32'h00);
    chk("t3a_flags", 32'(ofl), 32'b011);
    do_op(1, mk(OP_ADD, 4'd0, 8'h7F, 8'h01), oy, ofl, oid);
    chk("t3b_y", 32'(oy), 32'h80);
    chk("t3b_flags", 32'(ofl), 32'b100);
    chk("t3b_id", 32'(oid), 1);

    // 4: ALU_LAT=3, response back-pressured for 5 cycles
    req_cmd3 = {mk(OP_SUB, 4'd0, 8'h09, 8'h01), mk(OP_ADD, 4'd0, 8'h05, 8'h03)};
    rsp_ready3 = 1'b0;
    req_valid3 = 2'b01;
    chk("t4_idle_ready", 32'(req_ready3), 1);
    @(posedge clk); #1;
    req_valid3 = 2'b11;
    for (int i = 1; i <= 3; i++) begin
      chk("t4_exec_valid", 32'(rsp_valid3), 0);
      chk("t4_exec_ready", 32'(req_ready3), 0);
      @(posedge clk); #1;
    end
    req_cmd3[22:0] = mk(OP_OR, 4'd0, 8'hF0, 8'h0F);
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", 32'(rsp_valid3), 1);
      chk("t4_hold_y",     32'(rsp_y3), 32'h08);
      chk("t4_hold_ready", 32'(req_ready3), 0);
      chk("t4_hold_alu_a", 32'(alu_a3), 32'h05);
      @(posedge clk); #1;
    end
    rsp_ready3 = 1'b1;
    @(posedge clk); #1;
    chk("t4_after_valid", 32'(rsp_valid3), 0);
    chk("t4_after_grant", 32'(req_ready3), 32'b10);
    req_valid3 = 2'b00;

    // 5: reset during EXEC abandons the operation and restores tie priority
    req_cmd[22:0] = mk(OP_ADD, 4'd0, 8'h11, 8'h22);
    req_valid = 2'b01;
    @(posedge clk); #1;
    req_valid = 2'b00;
    chk("t5_in_exec", 32'(alu_a), 32'h11);
    rst_n = 1'b0;
    @(posedge clk); #1;
    req_valid = 2'b11;
    chk("t5_rst_valid", 32'(rsp_valid), 0);
    chk("t5_rst_alu_a", 32'(alu_a), 0);
    chk("t5_rst_ready", 32'(req_ready), 0);
    @(posedge clk); #1;
    chk("t5_rst_valid2", 32'(rsp_valid), 0);
    rst_n = 1'b1;
    chk("t5_tie_grant", 32'(req_ready), 32'b01);
    req_valid = 2'b00;
    @(posedge clk); #1;

`ifdef ALU_SHARE_STICKY_EN
    // 6: sticky flags accumulate; clear coinciding with capture keeps new flags only
    chk("t6_sticky_rst", 32'(sticky_flags), 0);
    do_op(0, mk(OP_ADD, 4'd0, 8'hFF, 8'h02), oy, ofl, oid);
    chk("t6_sticky_carry", 32'(sticky_flags), 32'b010);
    do_op(1, mk(OP_AND, 4'd0, 8'h00, 8'h00), oy, ofl, oid);
    chk("t6_sticky_both", 32'(sticky_flags), 32'b011);
    req_cmd[22:0] = mk(OP_ADD, 4'd0, 8'h7F, 8'h01);
    req_valid = 2'b01;
    @(posedge clk); #1;
    req_valid = 2'b00;
    sticky_clr = 1'b1;
    @(posedge clk); #1;
    sticky_clr = 1'b0;
    chk("t6_sticky_clr_cap", 32'(sticky_flags), 32'b100);
    chk("t6_rsp_valid", 32'(rsp_valid), 1);
    @(posedge clk); #1;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
